logo_bounce_ctrl: RTL
=====================

Name: logo_bounce_ctrl

Overview:
- Screen-saver sequencer for the 80x96 B&W logo image ROM (1-cycle registered read).
- Holds the logo's on-screen position and moves it once per frame, reversing direction at the screen edges.
- Maps the VGA scan coordinates to ROM x_img/y_img addresses and gates the returned pixel to the logo window.
- Sits between the VGA timing generator and the logo ROM; pixel_out feeds the colour mux.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- IMG_W, 80, logo width; must be ≤128.
- IMG_H, 96, logo height; must be ≤128.
- STEP, 2, pixels moved per axis per frame; 1..IMG_W.
- INIT_X, 100, reset X position.
- INIT_Y, 50, reset Y position.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- run  in  1  1 = logo moves; 0 = position frozen
- hc  in  10  current horizontal scan position
- vc  in  10  current vertical scan position
- active  in  1  scan is in the visible area
- pixel_in  in  1  ROM pixel, valid one cycle after x_img/y_img
- x_img  out  7  ROM column address
- y_img  out  7  ROM row address
- pixel_out  out  1  logo pixel aligned 3 cycles after hc/vc
- pos_x  out  10  current logo left edge
- pos_y  out  10  current logo top edge
- busy  out  1  position-update FSM not in IDLE

Behaviour:
- Reset (async, rst=1): pos_x=INIT_X, pos_y=INIT_Y, dir_x=dir_y=+ (increasing), FSM=IDLE; x_img, y_img, pixel_out, busy = 0; all pipeline flags cleared.
- Limits: MAX_X = SCREEN_W-IMG_W (560), MAX_Y = SCREEN_H-IMG_H (384).
- Address stage, cycle 0→1:
  - in_win = active & (pos_x ≤ hc < pos_x+IMG_W) & (pos_y ≤ vc < pos_y+IMG_H).
  - Compare in 11-bit arithmetic; no wrap-around.
  - Registered: x_img = in_win ? (hc-pos_x)[6:0] : 0; y_img = in_win ? (vc-pos_y)[6:0] : 0; win_d1 = in_win.
- ROM stage, cycle 1→2: win_d2 = win_d1, aligned with pixel_in.
- Output stage, cycle 2→3: pixel_out = pixel_in & win_d2.
- Total latency hc/vc → pixel_out is exactly 3 clocks. The pipeline runs every cycle, independent of the FSM.
- FSM states: IDLE, MOVE_X, MOVE_Y.
  - IDLE → MOVE_X on frame_tick & run; otherwise stays in IDLE.
  - MOVE_X → MOVE_Y unconditionally, after updating X.
  - MOVE_Y → IDLE unconditionally, after updating Y.
  - busy = (state ≠ IDLE).
  - frame_tick while busy is ignored, not queued.
- Axis update (X shown; Y identical with MAX_Y):
  - dir=+ and pos+STEP ≥ MAX_X: pos=MAX_X, dir=−, bounce event.
  - dir=− and pos ≤ STEP: pos=0, dir=+, bounce event.
  - Otherwise pos = pos ± STEP.
- pos_x/pos_y never leave [0, MAX]. A corner hit flips both directions, in consecutive cycles.
- run=0: FSM stays IDLE; pos and dir hold; the pipeline still displays the logo.
- Reset mid-update (e.g. in MOVE_Y): everything returns to reset values immediately; the partial update is discarded.

Optional Feature:
- Macro: LOGO_BOUNCE_COLOR_EN.
- Defined:
  - Adds output color[2:0], reset 3'b111.
  - Each bounce event increments color modulo 8, skipping 3'b000 (7 wraps to 1).
  - A corner hit increments twice.
  - color is held stable outside MOVE_X/MOVE_Y.
- Undefined: no color port, no extra logic; the screen uses fixed white.

Test Plan:
- Reset: assert rst mid-cycle → pos_x=100, pos_y=50, pixel_out=0, busy=0, all asynchronously; after release, no movement until frame_tick.
- Pipeline: pos=(100,50), active=1, drive hc=110, vc=60, pixel_in=1 two cycles later → x_img=10, y_img=10 at +1; pixel_out=1 at +3. hc=99 or hc=180 → x_img=0 and pixel_out=0 regardless of pixel_in.
- Movement: run=1, one frame_tick → busy high 2 cycles; pos=(102,52). Second frame_tick during busy → ignored, pos still (102,52).
- Right/bottom bounce: force pos_x=559 dir + → next frame pos_x=560, dir −; following frame pos_x=558. Same for pos_y=383 → 384.
- Left bounce and corner: pos=(1,1), dirs − → pos=(0,0), both dirs +. With LOGO_BOUNCE_COLOR_EN, color 7→2 (two increments, skipping 0).
- Freeze: run=0, 5 frame_ticks → pos unchanged, busy never asserted, pixel_out still follows the window.

Source files
------------

// File: rtl/logo_bounce_ctrl.sv
// Screen-saver sequencer for the logo ROM: bounces the logo around the screen once per frame
// and maps scan coordinates to ROM addresses. Optional bounce colour cycling: LOGO_BOUNCE_COLOR_EN.
module logo_bounce_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int IMG_W    = 80,
    parameter int IMG_H    = 96,
    parameter int STEP     = 2,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       run,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       active,
    input  logic       pixel_in,
    output logic [6:0] x_img,
    output logic [6:0] y_img,
    output logic       pixel_out,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       busy
`ifdef LOGO_BOUNCE_COLOR_EN
    ,
    output logic [2:0] color
`endif
);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;

    localparam logic [10:0] MAX_X   = 11'(SCREEN_W - IMG_W);
    localparam logic [10:0] MAX_Y   = 11'(SCREEN_H - IMG_H);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] IMG_W_W = 11'(IMG_W);
    localparam logic [10:0] IMG_H_W = 11'(IMG_H);
    localparam logic [9:0]  INIT_XW = 10'(INIT_X);
    localparam logic [9:0]  INIT_YW = 10'(INIT_Y);
    localparam logic        DIR_INC = 1'b0;
    localparam logic        DIR_DEC = 1'b1;

    state_t     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;

    logic [6:0] x_img_q, x_img_d, y_img_q, y_img_d;
    logic       win_d1_q, win_d2_q, pixel_out_q;
    logic       in_win;

    // Window test is done in 11 bits so pos+IMG never wraps; the ROM offset only needs 7 bits.
    always_comb begin
        in_win = active
              && ({1'b0, hc} >= {1'b0, pos_x_q}) && ({1'b0, hc} < ({1'b0, pos_x_q} + IMG_W_W))
              && ({1'b0, vc} >= {1'b0, pos_y_q}) && ({1'b0, vc} < ({1'b0, pos_y_q} + IMG_H_W));
        x_img_d = in_win ? (hc[6:0] - pos_x_q[6:0]) : 7'd0;
        y_img_d = in_win ? (vc[6:0] - pos_y_q[6:0]) : 7'd0;
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        case (state_q)
            IDLE: begin
                if (frame_tick && run) state_d = MOVE_X;
            end
            MOVE_X: begin
                state_d = MOVE_Y;
                if (dir_x_q == DIR_INC) begin
                    if (({1'b0, pos_x_q} + STEP_W) >= MAX_X) begin
                        pos_x_d = MAX_X[9:0];
                        dir_x_d = DIR_DEC;
                    end else begin
                        pos_x_d = pos_x_q + STEP_W[9:0];
                    end
                end else if (pos_x_q <= STEP_W[9:0]) begin
                    pos_x_d = 10'd0;
                    dir_x_d = DIR_INC;
                end else begin
                    pos_x_d = pos_x_q - STEP_W[9:0];
                end
            end
            MOVE_Y: begin
                state_d = IDLE;
                if (dir_y_q == DIR_INC) begin
                    if (({1'b0, pos_y_q} + STEP_W) >= MAX_Y) begin
                        pos_y_d = MAX_Y[9:0];
                        dir_y_d = DIR_DEC;
                    end else begin
                        pos_y_d = pos_y_q + STEP_W[9:0];
                    end
                end else if (pos_y_q <= STEP_W[9:0]) begin
                    pos_y_d = 10'd0;
                    dir_y_d = DIR_INC;
                end else begin
                    pos_y_d = pos_y_q - STEP_W[9:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_x_q     <= INIT_XW;
            pos_y_q     <= INIT_YW;
            dir_x_q     <= DIR_INC;
            dir_y_q     <= DIR_INC;
            x_img_q     <= 7'd0;
            y_img_q     <= 7'd0;
            win_d1_q    <= 1'b0;
            win_d2_q    <= 1'b0;
            pixel_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            x_img_q     <= x_img_d;
            y_img_q     <= y_img_d;
            win_d1_q    <= in_win;
            win_d2_q    <= win_d1_q;
            pixel_out_q <= pixel_in & win_d2_q;
        end
    end

`ifdef LOGO_BOUNCE_COLOR_EN
    logic [2:0] color_q, color_d;
    logic       bounce;

    // A direction flip is exactly a bounce; corners flip X and Y in consecutive cycles.
    always_comb begin
        bounce  = ((state_q == MOVE_X) && (dir_x_d != dir_x_q))
               || ((state_q == MOVE_Y) && (dir_y_d != dir_y_q));
        color_d = color_q;
        if (bounce) color_d = (color_q == 3'd7) ? 3'd1 : (color_q + 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) color_q <= 3'b111;
        else     color_q <= color_d;
    end

    assign color = color_q;
`endif

    assign x_img     = x_img_q;
    assign y_img     = y_img_q;
    assign pixel_out = pixel_out_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign busy      = (state_q != IDLE);

endmodule
